// File: rtl/btb_lookup.sv
`default_nettype none
// ============================================================================
// btb_lookup : 2-way set-associative BTB storage with registered IF-stage
//              prediction and EX-stage write-back port.
// Revision   : 1.0
// ============================================================================
module btb_lookup #(
  parameter int SETS  = 8,
  parameter int TAG_W = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_lookup_en,
  input  logic [31:0]             i_lookup_pc,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_pred_valid,
  output logic                    o_pred_hit,
  output logic                    o_pred_taken,
  output logic [31:0]             o_pred_next_pc,
  input  logic [$clog2(SETS)-1:0] i_update_index,
  output logic [127:0]            o_update_set,
  output logic [SETS-1:0]         o_lru,
  input  logic                    i_update_en,
  input  logic [127:0]            i_write_set,
  input  logic                    i_next_lru_write
);

  localparam int IDX_W = $clog2(SETS);

  logic [127:0]      r_array [SETS];
  logic [SETS-1:0]   r_lru;
  logic              r_pred_valid;
  logic              r_pred_hit;
  logic              r_pred_taken;
  logic [31:0]       r_pred_next_pc;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [127:0]      w_set;
  logic [63:0]       w_way1;
  logic [63:0]       w_way2;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_hit;
  logic              w_taken;
  logic [31:0]       w_next_pc;
  logic              w_lookup_go;
  logic              w_unused;

  assign w_idx       = i_lookup_pc[IDX_W+1:2];
  assign w_tag       = i_lookup_pc[31:32-TAG_W];
  assign w_unused    = &{1'b0, i_lookup_pc[1:0]};
  assign w_lookup_go = i_lookup_en && !i_stall;

  // Same-cycle write to the looked-up set is forwarded into the lookup.
  assign w_set  = (i_update_en && (i_update_index == w_idx)) ? i_write_set
                                                             : r_array[w_idx];
  assign w_way1 = w_set[127:64];
  assign w_way2 = w_set[63:0];

  assign w_hit1 = w_way1[63] && (w_way1[62 -: TAG_W] == w_tag);
  assign w_hit2 = w_way2[63] && (w_way2[62 -: TAG_W] == w_tag);
  assign w_hit  = w_hit1 || w_hit2;

  always_comb begin
    w_taken   = 1'b0;
    w_next_pc = i_lookup_pc + 32'd4;
    if (w_hit1) begin
      w_taken = w_way1[3];
      if (w_way1[3]) w_next_pc = w_way1[35:4];
    end else if (w_hit2) begin
      w_taken = w_way2[3];
      if (w_way2[3]) w_next_pc = w_way2[35:4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid   <= 1'b0;
      r_pred_hit     <= 1'b0;
      r_pred_taken   <= 1'b0;
      r_pred_next_pc <= 32'd0;
    end else if (i_flush) begin
      r_pred_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_lookup_en) begin
        r_pred_valid   <= 1'b1;
        r_pred_hit     <= w_hit;
        r_pred_taken   <= w_taken;
        r_pred_next_pc <= w_next_pc;
      end else begin
        r_pred_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        r_array[i] <= '0;
      end
    end else if (i_update_en) begin
      r_array[i_update_index] <= i_write_set;
    end
  end

  // The write-side assignment comes last so it wins an index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lru <= '0;
    end else begin
      if (w_lookup_go && w_hit) begin
        r_lru[w_idx] <= !w_hit1;
      end
      if (i_update_en) begin
        r_lru[i_update_index] <= i_next_lru_write;
      end
    end
  end

  assign o_pred_valid   = r_pred_valid;
  assign o_pred_hit     = r_pred_hit;
  assign o_pred_taken   = r_pred_taken;
  assign o_pred_next_pc = r_pred_next_pc;
  assign o_update_set   = r_array[i_update_index];
  assign o_lru          = r_lru;

endmodule
`default_nettype wire

// File: tb/tb_btb_lookup.sv
`default_nettype none
// ============================================================================
// tb_btb_lookup : randomized scoreboard bench for btb_lookup against a
//                 field-level behavioural model.
// Revision      : 1.0
// ============================================================================
module tb_btb_lookup;

  typedef struct packed {
    logic        v;
    logic [26:0] tag;
    logic [31:0] tgt;
    logic [1:0]  st;
  } way_t;

  typedef struct {
    logic         pv;
    logic         ph;
    logic         pt;
    logic [31:0]  npc;
    logic [7:0]   lru;
    logic [127:0] us;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lookup_en = 1'b0;
  logic [31:0]  lookup_pc = '0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         pred_valid;
  logic         pred_hit;
  logic         pred_taken;
  logic [31:0]  pred_next_pc;
  logic [2:0]   update_index = '0;
  logic [127:0] update_set;
  logic [7:0]   lru;
  logic         update_en = 1'b0;
  logic [127:0] write_set = '0;
  logic         next_lru_write = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];

  way_t        m_arr [8][2];
  logic [7:0]  m_lru;
  logic        m_pv, m_ph, m_pt;
  logic [31:0] m_npc;

  always #5 clk = ~clk;

  btb_lookup #(.SETS(8), .TAG_W(27)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_lookup_en      (lookup_en),
    .i_lookup_pc      (lookup_pc),
    .i_stall          (stall),
    .i_flush          (flush),
    .o_pred_valid     (pred_valid),
    .o_pred_hit       (pred_hit),
    .o_pred_taken     (pred_taken),
    .o_pred_next_pc   (pred_next_pc),
    .i_update_index   (update_index),
    .o_update_set     (update_set),
    .o_lru            (lru),
    .i_update_en      (update_en),
    .i_write_set      (write_set),
    .i_next_lru_write (next_lru_write)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input way_t w);
    return {w, 2'b00};
  endfunction

  function automatic logic [26:0] rand_tag();
    case ($urandom % 4)
      0:       return 27'h80;
      1:       return 27'h1;
      2:       return 27'h7FF_FFFF;
      default: return 27'h55;
    endcase
  endfunction

  function automatic way_t rand_way();
    way_t        w;
    logic [31:0] t;
    t     = $urandom;
    w.v   = ($urandom % 4) != 0;
    w.tag = rand_tag();
    w.tgt = {t[31:2], 2'b00};
    w.st  = 2'($urandom % 4);
    return w;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_arr[s][0] = '0;
      m_arr[s][1] = '0;
    end
    m_lru = '0;
    m_pv  = 1'b0;
    m_ph  = 1'b0;
    m_pt  = 1'b0;
    m_npc = '0;
  endtask

  // Drive one cycle of stimulus, advance the model, and queue the expectation.
  task automatic step(input logic le, input logic [31:0] pc, input logic st,
                      input logic fl, input logic ue, input logic [2:0] ui,
                      input way_t w1, input way_t w2, input logic nl);
    way_t s1, s2;
    int   hw;
    int   idx;
    exp_t e;
    @(negedge clk);
    lookup_en      = le;
    lookup_pc      = pc;
    stall          = st;
    flush          = fl;
    update_en      = ue;
    update_index   = ui;
    write_set      = {pk(w1), pk(w2)};
    next_lru_write = nl;

    idx = int'(pc[4:2]);
    s1  = m_arr[idx][0];
    s2  = m_arr[idx][1];
    if (ue && int'(ui) == idx) begin
      s1 = w1;
      s2 = w2;
    end
    hw = -1;
    if (s1.v && s1.tag == pc[31:5]) hw = 0;
    else if (s2.v && s2.tag == pc[31:5]) hw = 1;

    if (fl) begin
      m_pv = 1'b0;
    end else if (!st) begin
      if (le) begin
        m_pv  = 1'b1;
        m_ph  = (hw >= 0);
        m_pt  = (hw == 0) ? s1.st[1] : (hw == 1) ? s2.st[1] : 1'b0;
        m_npc = !m_pt ? pc + 32'd4 : (hw == 0) ? s1.tgt : s2.tgt;
      end else begin
        m_pv = 1'b0;
      end
    end
    if (le && !st && hw >= 0) m_lru[idx] = (hw == 1);
    if (ue) begin
      m_arr[ui][0] = w1;
      m_arr[ui][1] = w2;
      m_lru[ui]    = nl;
    end

    e.pv  = m_pv;
    e.ph  = m_ph;
    e.pt  = m_pt;
    e.npc = m_npc;
    e.lru = m_lru;
    e.us  = {pk(m_arr[ui][0]), pk(m_arr[ui][1])};
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pred_valid",   128'(pred_valid),   128'(e.pv));
        check("pred_hit",     128'(pred_hit),     128'(e.ph));
        check("pred_taken",   128'(pred_taken),   128'(e.pt));
        check("pred_next_pc", 128'(pred_next_pc), 128'(e.npc));
        check("lru",          128'(lru),          128'(e.lru));
        check("update_set",   update_set,         e.us);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_pred_valid"},   128'(pred_valid),   128'd0);
    check({tag, "_pred_hit"},     128'(pred_hit),     128'd0);
    check({tag, "_pred_taken"},   128'(pred_taken),   128'd0);
    check({tag, "_pred_next_pc"}, 128'(pred_next_pc), 128'd0);
    check({tag, "_lru"},          128'(lru),          128'd0);
    check({tag, "_update_set"},   update_set,         128'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    way_t        z, wa, wb;
    logic [31:0] pc;
    z = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 3'd0, z, z, 1'b0);

    wa = '{1'b1, 27'h80, 32'h2000_0000, 2'b10};
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, wa, z, 1'b0);
    step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 3'd0, z, z, 1'b0);

    wb = '{1'b1, 27'h123, 32'h3000_0000, 2'b01};
    pc = {27'h123, 3'd3, 2'b00};
    step(1'b1, pc, 1'b0, 1'b0, 1'b1, 3'd3, z, wb, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd3, z, z, 1'b0);

    step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 3'd0, z, z, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 3'd0, z, z, 1'b0);
    end

    step(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 3'd0, z, z, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      pc = {rand_tag(), 3'($urandom % 8), 2'($urandom % 4)};
      step(($urandom % 4) != 0, pc, ($urandom % 6) == 0, ($urandom % 10) == 0,
           ($urandom % 3) == 0, 3'($urandom % 8), rand_way(), rand_way(),
           1'($urandom % 2));
    end

    for (int s = 0; s < 8; s++) begin
      wa = '{1'b1, 27'h80, 32'h4000_0000 + 32'(s * 16), 2'b11};
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'(s), wa, rand_way(), 1'b1);
    end
    for (int s = 0; s < 8; s++) begin
      step(1'b1, {27'h80, 3'(s), 2'b00}, 1'b0, 1'b0, 1'b0, 3'(s), z, z, 1'b0);
    end

    @(negedge clk);
    lookup_en = 1'b0;
    update_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step(1'b1, {27'h80, 3'(s), 2'b00}, 1'b0, 1'b0, 1'b0, 3'(s), z, z, 1'b0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
